cache_read_responder: RTL and testbench
=======================================

Name: cache_read_responder

Overview:
- Sits directly downstream of the cache access arbiter and cache bank, on the read-return path back into the router.
- Captures per-port read completions: readReady, requester network address, cache read data and bank address.
- Queues completions per port and merges them round-robin into one response packet stream toward the local router injection port.

Parameters:
- DATA_W, 32, width of a cache data word (equals global DATA_WIDTH).
- NET_ADDR_W, 4, width of a network node address (equals global NETWORK_ADDRESS_WIDTH).
- BANK_ADDR_W, 8, width of a cache bank word address (equals global CACHE_BANK_ADDRESS_WIDTH).
- FIFO_DEPTH, 4, entries per lane FIFO; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd_valid  in  4  per-lane read completion strobe; bit order 0=NORTH, 1=SOUTH, 2=EAST, 3=WEST.
- rd_requester  in  4*NET_ADDR_W  per-lane requester address; lane i occupies bits [i*NET_ADDR_W +: NET_ADDR_W].
- rd_addr  in  4*BANK_ADDR_W  per-lane bank address of the read.
- rd_data  in  4*DATA_W  per-lane cache read data.
- resp_valid  out  1  response packet valid.
- resp_ready  in  1  downstream accepts the packet when high with resp_valid.
- resp_dest  out  NET_ADDR_W  destination, equal to the original requester.
- resp_port  out  2  lane the response came from.
- resp_addr  out  BANK_ADDR_W  bank address of the read.
- resp_data  out  DATA_W  read data.
- lane_full  out  4  per-lane FIFO full flag.
- drop_pulse  out  4  one-cycle pulse per lane when a completion is discarded.

Behaviour:
- Reset: all FIFOs empty, resp_valid=0, resp_dest/resp_port/resp_addr/resp_data=0, lane_full=0, drop_pulse=0, round-robin pointer=3 so lane 0 has first priority.
- Enqueue: at each rising edge, every lane with rd_valid[i]=1 writes {requester, addr, data} into FIFO i. All four lanes may enqueue in the same cycle.
- Full lane: if FIFO i is full and not being popped that edge, the entry is discarded and drop_pulse[i]=1 for the next cycle.
  - Full with simultaneous pop: the push is accepted and the count is unchanged.
- Output register: loaded when resp_valid=0 or (resp_valid and resp_ready).
  - The winning lane's FIFO head is popped into the register at that edge.
  - If no lane is non-empty, resp_valid goes to 0.
- Latency: a completion sampled at edge k can appear on resp_* after edge k+1 at the earliest. No combinational path from rd_* to resp_*.
- Stall: while resp_valid=1 and resp_ready=0, all resp_* outputs hold stable and no FIFO is popped.
- Arbitration: round-robin over non-empty lanes.
  - Search starts at pointer+1, modulo 4.
  - The pointer updates to the granted lane only on a pop.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits with wrap-bit compare; full when the counts differ by FIFO_DEPTH.
- lane_full is registered and reflects post-edge occupancy.
- Reset asserted mid-operation: all queued and held packets are discarded; the reset values listed above apply on the next edge.

Optional Feature:
- Macro RESP_DROP_COUNT_EN.
- Defined: adds output drop_count[15:0], a saturating count of total discarded completions across all lanes.
  - Increments by popcount(drop events) per cycle and holds at 16'hFFFF.
  - Cleared by reset.
- Undefined: no port, no counter logic; drop_pulse still present.

Decomposition:
- Shared global defines: DATA_WIDTH, NETWORK_ADDRESS_WIDTH, CACHE_BANK_ADDRESS_WIDTH, the lane index constants (NORTH=0, SOUTH=1, EAST=2, WEST=3) and the response packet field widths.
- One sub-module: resp_lane_fifo, a synchronous single-clock FIFO with push, pop, full, empty and head.
- It is instantiated four times; the arbiter and output register stay in the top module.

Test Plan:
- Single read: rd_valid=4'b0001, requester=5, addr=8'h10, data=32'hDEADBEEF, resp_ready=1. Expect resp_valid high after the next edge with dest=5, port=0, addr=8'h10, data matching, then resp_valid low.
- All four lanes valid in one cycle with distinct data, resp_ready=1. Expect four consecutive responses in port order 0,1,2,3 with no gaps.
- resp_ready=0 for 10 cycles while lane 2 pushes 6 completions (FIFO_DEPTH=4).
  - Expect one held in the output register and 4 queued; lane_full[2]=1.
  - The 6th completion yields drop_pulse[2]=1.
  - After release, exactly 5 responses in order.
- Fairness: lanes 0 and 3 continuously valid, resp_ready=1. Expect alternating port 0,3,0,3; no starvation.
- Stall stability: resp_ready toggled randomly. Expect resp_* to never change while valid and not ready, and no duplicated or lost packets versus a scoreboard.
- Reset with 3 entries queued and resp_valid=1. Expect resp_valid=0, lane_full=0 after the reset edge, and no stale responses afterward; with RESP_DROP_COUNT_EN, drop_count=0.

Source files
------------

// File: rtl/cache_read_responder_pkg.sv
// Shared globals for the cache read-return path: bus widths, lane indices, round-robin helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cache_read_responder_pkg;

  localparam int DATA_WIDTH               = 32;
  localparam int NETWORK_ADDRESS_WIDTH    = 4;
  localparam int CACHE_BANK_ADDRESS_WIDTH = 8;

  localparam int NUM_LANES       = 4;
  localparam int RESP_PORT_WIDTH = 2;

  // Lane index constants, matching the rd_valid bit order.
  typedef enum logic [1:0] {
    NORTH = 2'd0,
    SOUTH = 2'd1,
    EAST  = 2'd2,
    WEST  = 2'd3
  } lane_e;

  // Round-robin pick: first requesting lane at ptr+1, ptr+2, ... (ptr itself last).
  // Returns {found, lane}.
  function automatic logic [2:0] rrPick(input logic [1:0] ptr, input logic [3:0] req);
    logic [1:0] idx;
    rrPick = '0;
    // Walk from lowest priority to highest so the last hit wins.
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rrPick = {1'b1, idx};
    end
  endfunction

endpackage

// File: rtl/cache_read_responder_resp_lane_fifo.sv
// Single-clock per-lane completion FIFO with wrap-bit pointers and a register-array head.
// Latency: a push is visible at head after the edge that writes it; head is read combinationally.
// Backpressure: push is dropped when full unless a pop happens on the same edge.
module resp_lane_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  logic         doPush;
  logic         doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = ((wrPtr - rdPtr) == (AW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr[AW-1:0]];

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/cache_read_responder.sv
// Queues per-lane cache read completions and merges them round-robin into one response stream.
// Latency: completion sampled at edge k is on resp_* after edge k+1 at the earliest (fully registered).
// Backpressure: resp_ready low holds resp_* and stops pops; full lanes drop with drop_pulse.
// Optional: define RESP_DROP_COUNT_EN to add the saturating drop_count output.
module cache_read_responder
  import cache_read_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_WIDTH,
  parameter int NET_ADDR_W  = NETWORK_ADDRESS_WIDTH,
  parameter int BANK_ADDR_W = CACHE_BANK_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_LANES-1:0]             rd_valid,
  input  logic [NUM_LANES*NET_ADDR_W-1:0]  rd_requester,
  input  logic [NUM_LANES*BANK_ADDR_W-1:0] rd_addr,
  input  logic [NUM_LANES*DATA_W-1:0]      rd_data,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [NET_ADDR_W-1:0]            resp_dest,
  output logic [RESP_PORT_WIDTH-1:0]       resp_port,
  output logic [BANK_ADDR_W-1:0]           resp_addr,
  output logic [DATA_W-1:0]                resp_data,
  output logic [NUM_LANES-1:0]             lane_full,
`ifdef RESP_DROP_COUNT_EN
  output logic [15:0]                      drop_count,
`endif
  output logic [NUM_LANES-1:0]             drop_pulse
);

  localparam int ENTRY_W = NET_ADDR_W + BANK_ADDR_W + DATA_W;

  logic [ENTRY_W-1:0]   laneHead [NUM_LANES];
  logic [NUM_LANES-1:0] laneEmpty;
  logic [NUM_LANES-1:0] laneFull;
  logic [NUM_LANES-1:0] popVec;
  logic [NUM_LANES-1:0] dropNow;
  logic [ENTRY_W-1:0]   headSel;
  logic [2:0]           pick;
  logic                 loadReg;
  logic [1:0]           rrPtr;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    resp_lane_fifo #(
      .W    (ENTRY_W),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (rd_valid[i]),
      .pushData({rd_requester[i*NET_ADDR_W +: NET_ADDR_W],
                 rd_addr[i*BANK_ADDR_W +: BANK_ADDR_W],
                 rd_data[i*DATA_W +: DATA_W]}),
      .pop     (popVec[i]),
      .full    (laneFull[i]),
      .empty   (laneEmpty[i]),
      .head    (laneHead[i])
    );
  end

  // Full flags come straight from registered FIFO pointers.
  assign lane_full = laneFull;

  // Arbitrate over non-empty lanes and derive pops and drops for this edge.
  always_comb begin
    pick    = rrPick(rrPtr, ~laneEmpty);
    loadReg = !resp_valid || resp_ready;
    popVec  = '0;
    if (loadReg && pick[2]) popVec[pick[1:0]] = 1'b1;
    dropNow = rd_valid & laneFull & ~popVec;
    headSel = laneHead[pick[1:0]];
  end

  // Output register: reload when empty or accepted; pointer moves only on a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_dest  <= '0;
      resp_port  <= '0;
      resp_addr  <= '0;
      resp_data  <= '0;
      rrPtr      <= 2'(WEST);
    end else if (loadReg) begin
      if (pick[2]) begin
        resp_valid <= 1'b1;
        resp_dest  <= headSel[ENTRY_W-1 -: NET_ADDR_W];
        resp_port  <= pick[1:0];
        resp_addr  <= headSel[DATA_W +: BANK_ADDR_W];
        resp_data  <= headSel[DATA_W-1:0];
        rrPtr      <= pick[1:0];
      end else begin
        resp_valid <= 1'b0;
      end
    end
  end

  // One-cycle drop indication per lane.
  always_ff @(posedge clk) begin
    if (reset) drop_pulse <= '0;
    else       drop_pulse <= dropNow;
  end

`ifdef RESP_DROP_COUNT_EN
  logic [16:0] dropSum;
  assign dropSum = {1'b0, drop_count} + 17'($countones(dropNow));

  // Saturating total of discarded completions across all lanes.
  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else       drop_count <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
  end
`endif

endmodule

// File: tb/tb_cache_read_responder.sv
// Directed bench for cache_read_responder: reset, single read, all lanes, stall/drop, fairness, random stall, mid reset.
// Latency: checks first response one edge after capture.
// Backpressure: drives resp_ready low/random and tracks drops per lane.
module tb_cache_read_responder;

  logic         clk;
  logic         reset;
  logic [3:0]   rd_valid;
  logic [15:0]  rd_requester;
  logic [31:0]  rd_addr;
  logic [127:0] rd_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [3:0]   resp_dest;
  logic [1:0]   resp_port;
  logic [7:0]   resp_addr;
  logic [31:0]  resp_data;
  logic [3:0]   lane_full;
  logic [3:0]   drop_pulse;
`ifdef RESP_DROP_COUNT_EN
  logic [15:0]  drop_count;
`endif

  int checks = 0;
  int fails  = 0;

  cache_read_responder dut (
    .clk         (clk),
    .reset       (reset),
    .rd_valid    (rd_valid),
    .rd_requester(rd_requester),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_dest   (resp_dest),
    .resp_port   (resp_port),
    .resp_addr   (resp_addr),
    .resp_data   (resp_data),
    .lane_full   (lane_full),
`ifdef RESP_DROP_COUNT_EN
    .drop_count  (drop_count),
`endif
    .drop_pulse  (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setLane(input int i, input logic [3:0] rq, input logic [7:0] a, input logic [31:0] d);
    rd_requester[i*4 +: 4]  = rq;
    rd_addr[i*8 +: 8]       = a;
    rd_data[i*32 +: 32]     = d;
  endtask

  task automatic doReset;
    reset    = 1'b1;
    rd_valid = '0;
    tick();
    reset    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; rd_valid = '0; resp_ready = 1'b0;
    rd_requester = '0; rd_addr = '0; rd_data = '0;
    tick(); tick();
    checks++;
    if ({resp_valid, lane_full, drop_pulse} !== 9'd0) begin
      $display("FAIL reset_flags: got valid=%b full=%b drop=%b, want 0", resp_valid, lane_full, drop_pulse); fails++;
    end
    checks++;
    if ({resp_dest, resp_port, resp_addr, resp_data} !== 46'd0) begin
      $display("FAIL reset_fields: got dest=%h port=%h addr=%h data=%h, want 0", resp_dest, resp_port, resp_addr, resp_data); fails++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      $display("FAIL reset_idle: got valid=%b want 0", resp_valid); fails++;
    end
`ifdef RESP_DROP_COUNT_EN
    checks++;
    if (drop_count !== 16'd0) begin
      $display("FAIL reset_dropcount: got %0d want 0", drop_count); fails++;
    end
`endif
  endtask

  task automatic test_single;
    doReset();
    resp_ready = 1'b1;
    setLane(0, 4'd5, 8'h10, 32'hDEADBEEF);
    rd_valid = 4'b0001;
    tick();
    rd_valid = '0;
    checks++;
    if (resp_valid !== 1'b0) begin
      $display("FAIL single_latency: got valid=%b want 0 one edge after capture", resp_valid); fails++;
    end
    tick();
    checks++;
    if ({resp_valid, resp_dest, resp_port, resp_addr, resp_data} !== {1'b1, 4'd5, 2'd0, 8'h10, 32'hDEADBEEF}) begin
      $display("FAIL single_resp: got v=%b dest=%0d port=%0d addr=%h data=%h, want 1/5/0/10/deadbeef",
               resp_valid, resp_dest, resp_port, resp_addr, resp_data); fails++;
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      $display("FAIL single_drain: got valid=%b want 0", resp_valid); fails++;
    end
  endtask

  task automatic test_all_lanes;
    doReset();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) setLane(i, 4'(i + 1), 8'(8'h20 + i), 32'h1000_0000 + i);
    rd_valid = 4'b1111;
    tick();
    rd_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({resp_valid, resp_dest, resp_port, resp_addr, resp_data} !==
          {1'b1, 4'(i + 1), 2'(i), 8'(8'h20 + i), 32'h1000_0000 + i}) begin
        $display("FAIL all_lanes_%0d: got v=%b dest=%0d port=%0d addr=%h data=%h, want port %0d data %h",
                 i, resp_valid, resp_dest, resp_port, resp_addr, resp_data, i, 32'h1000_0000 + i); fails++;
      end
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      $display("FAIL all_lanes_drain: got valid=%b want 0", resp_valid); fails++;
    end
  endtask

  task automatic test_stall_drop;
    doReset();
    resp_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      setLane(2, 4'h7, 8'(8'h40 + n), 32'hC000_0000 + n);
      rd_valid = 4'b0100;
      tick();
      if (n >= 1) begin
        checks++;
        if ({resp_valid, resp_port, resp_data} !== {1'b1, 2'd2, 32'hC000_0000}) begin
          $display("FAIL stall_head_%0d: got v=%b port=%0d data=%h, want 1/2/c0000000", n, resp_valid, resp_port, resp_data); fails++;
        end
      end
      if (n == 4) begin
        checks++;
        if ({lane_full, drop_pulse} !== {4'b0100, 4'b0000}) begin
          $display("FAIL stall_full: got full=%b drop=%b, want 0100/0000", lane_full, drop_pulse); fails++;
        end
      end
      if (n == 5) begin
        checks++;
        if ({lane_full, drop_pulse} !== {4'b0100, 4'b0100}) begin
          $display("FAIL stall_drop: got full=%b drop=%b, want 0100/0100", lane_full, drop_pulse); fails++;
        end
`ifdef RESP_DROP_COUNT_EN
        checks++;
        if (drop_count !== 16'd1) begin
          $display("FAIL stall_dropcount: got %0d want 1", drop_count); fails++;
        end
`endif
      end
    end
    rd_valid = '0;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if ({resp_valid, resp_addr, resp_data, drop_pulse} !== {1'b1, 8'h40, 32'hC000_0000, 4'b0000}) begin
        $display("FAIL stall_hold_%0d: got v=%b addr=%h data=%h drop=%b, want held c0000000 no drop",
                 n, resp_valid, resp_addr, resp_data, drop_pulse); fails++;
      end
    end
    resp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({resp_valid, resp_port, resp_addr, resp_data} !== {1'b1, 2'd2, 8'(8'h40 + k), 32'hC000_0000 + k}) begin
        $display("FAIL stall_release_%0d: got v=%b port=%0d addr=%h data=%h, want data %h",
                 k, resp_valid, resp_port, resp_addr, resp_data, 32'hC000_0000 + k); fails++;
      end
      if (k == 1) begin
        checks++;
        if (lane_full !== 4'b0000) begin
          $display("FAIL stall_unfull: got full=%b want 0000", lane_full); fails++;
        end
      end
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      $display("FAIL stall_drain: got valid=%b want 0 after 5 responses", resp_valid); fails++;
    end
  endtask

  task automatic test_fairness;
    logic [1:0]  expPort;
    logic [31:0] expData;
    int          r;
    doReset();
    resp_ready = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      if (c <= 7) begin
        setLane(0, 4'h1, 8'h50, 32'hA000_0000 + (c - 1));
        setLane(3, 4'h2, 8'h60, 32'hB000_0000 + (c - 1));
        rd_valid = 4'b1001;
      end else begin
        rd_valid = '0;
      end
      tick();
      if (c >= 2) begin
        r = c - 2;
        expPort = (r % 2 == 1) ? 2'd3 : 2'd0;
        expData = ((r % 2 == 1) ? 32'hB000_0000 : 32'hA000_0000) + 32'(r / 2);
        checks++;
        if ({resp_valid, resp_port, resp_data, drop_pulse} !== {1'b1, expPort, expData, 4'b0000}) begin
          $display("FAIL fair_%0d: got v=%b port=%0d data=%h drop=%b, want port %0d data %h",
                   r, resp_valid, resp_port, resp_data, drop_pulse, expPort, expData); fails++;
        end
      end
    end
    rd_valid = '0;
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      $display("FAIL fair_drain: got valid=%b want 0", resp_valid); fails++;
    end
  endtask

  task automatic test_random_stall;
    logic [43:0] expQ [4][$];
    logic [46:0] prevSnap;
    logic [46:0] curSnap;
    logic [43:0] expEntry;
    logic        prevValid;
    logic        prevReady;
    logic [3:0]  rq;
    logic [7:0]  a;
    logic [31:0] d;
    doReset();
    prevValid = 1'b0;
    prevReady = 1'b1;
    prevSnap  = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      curSnap = {resp_valid, resp_dest, resp_port, resp_addr, resp_data};
      if (prevValid && !prevReady) begin
        checks++;
        if (curSnap !== prevSnap) begin
          $display("FAIL rand_hold_%0d: got %h want %h", cyc, curSnap, prevSnap); fails++;
        end
      end
      for (int i = 0; i < 4; i++)
        if (drop_pulse[i] && expQ[i].size() > 0) void'(expQ[i].pop_back());
      resp_ready = (cyc >= 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (resp_valid && resp_ready) begin
        checks++;
        if (expQ[resp_port].size() == 0) begin
          $display("FAIL rand_extra_%0d: got unexpected packet port=%0d data=%h, want none", cyc, resp_port, resp_data); fails++;
        end else begin
          expEntry = expQ[resp_port].pop_front();
          if ({resp_dest, resp_addr, resp_data} !== expEntry) begin
            $display("FAIL rand_pkt_%0d: got %h want %h on port %0d", cyc, {resp_dest, resp_addr, resp_data}, expEntry, resp_port); fails++;
          end
        end
      end
      prevSnap  = curSnap;
      prevValid = resp_valid;
      prevReady = resp_ready;
      rd_valid  = '0;
      if (cyc < 150) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            rq = 4'($urandom); a = 8'($urandom); d = $urandom;
            setLane(i, rq, a, d);
            rd_valid[i] = 1'b1;
            expQ[i].push_back({rq, a, d});
          end
        end
      end
      tick();
    end
    rd_valid = '0;
    checks++;
    if (resp_valid !== 1'b0 || expQ[0].size() + expQ[1].size() + expQ[2].size() + expQ[3].size() != 0) begin
      $display("FAIL rand_drain: got valid=%b left=%0d/%0d/%0d/%0d, want 0 and empty",
               resp_valid, expQ[0].size(), expQ[1].size(), expQ[2].size(), expQ[3].size()); fails++;
    end
  endtask

  task automatic test_reset_mid;
    doReset();
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) setLane(i, 4'hE, 8'h77, 32'h5555_0000 + i);
    rd_valid = 4'b1111;
    tick();
    rd_valid = '0;
    tick();
    checks++;
    if (resp_valid !== 1'b1) begin
      $display("FAIL midrst_pre: got valid=%b want 1", resp_valid); fails++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({resp_valid, lane_full, drop_pulse, resp_dest, resp_port, resp_addr, resp_data} !== 55'd0) begin
      $display("FAIL midrst_state: got v=%b full=%b data=%h, want all 0", resp_valid, lane_full, resp_data); fails++;
    end
`ifdef RESP_DROP_COUNT_EN
    checks++;
    if (drop_count !== 16'd0) begin
      $display("FAIL midrst_dropcount: got %0d want 0", drop_count); fails++;
    end
`endif
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
        $display("FAIL midrst_stale_%0d: got valid=%b data=%h want 0", n, resp_valid, resp_data); fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_lanes();
    test_stall_drop();
    test_fairness();
    test_random_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
